// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 8-bit 5-stage pipeline.
//   - Tracks in-flight register writes in EX and MEM with a two-entry scoreboard
//     and stalls ID on read-after-write hazards.
//   - Flushes IF/ID and ID/EX for BR_FLUSH_CYCLES cycles after a taken branch.
//   - Freezes the whole pipe while data memory is busy, with a timeout that
//     raises a one-cycle mem_err pulse and releases the pipe.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs1, id_rs2            ID source register addresses
//   id_rs1_used, id_rs2_used  corresponding source is actually read
//   id_rd, id_reg_en          ID destination register and its write enable
//   ex_brx_taken              branch in EX resolved taken this cycle
//   mem_req, mem_ready        MEM stage access request / completion
//   pc_en, ifid_en            PC and IF/ID load enables
//   ifid_flush, idex_flush    IF/ID and ID/EX bubble insertion
//   exmem_en                  EX/MEM (and ID/EX) load enable
//   mem_err                   one-cycle memory timeout pulse
//   stall_cycles              saturating count of non-RUN cycles
//
// The control outputs are combinational from the registered state plus the
// current inputs, so a hazard, branch or memory wait is acted on in the same
// cycle it is first seen.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_AW          = 2,
  parameter int BR_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_en,
  input  logic              ex_brx_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              mem_err,
  output logic [7:0]        stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HAZ_STALL = 2'd1,
    ST_BR_FLUSH  = 2'd2,
    ST_MEM_WAIT  = 2'd3
  } state_e;

  localparam logic [2:0] BR_RELOAD = 3'(BR_FLUSH_CYCLES - 1);
  localparam logic [7:0] MEM_LIMIT = 8'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [2:0]        br_cnt_q, br_cnt_d;
  logic [7:0]        mem_cnt_q, mem_cnt_d;
  logic [7:0]        stall_q, stall_d;
  logic              sb_ex_v_q, sb_ex_v_d;
  logic [REG_AW-1:0] sb_ex_rd_q, sb_ex_rd_d;
  logic              sb_mem_v_q, sb_mem_v_d;
  logic [REG_AW-1:0] sb_mem_rd_q, sb_mem_rd_d;

  logic hazard_s;
  logic mem_timeout_s;
  logic mem_block_s;
  logic br_active_s;
  logic run_decode_s;
  logic pc_en_s, ifid_en_s, ifid_flush_s, idex_flush_s, exmem_en_s, mem_err_s;

  // True when register r is the destination of a valid in-flight write.
  function automatic logic sb_match(
    input logic              ex_v,
    input logic [REG_AW-1:0] ex_rd,
    input logic              mem_v,
    input logic [REG_AW-1:0] mem_rd,
    input logic [REG_AW-1:0] r
  );
    return (ex_v && (ex_rd == r)) || (mem_v && (mem_rd == r));
  endfunction

  // Hazard, timeout and branch qualifiers shared by next-state and output decode.
  always_comb begin
    hazard_s = id_valid &&
               ((id_rs1_used && sb_match(sb_ex_v_q, sb_ex_rd_q, sb_mem_v_q, sb_mem_rd_q, id_rs1)) ||
                (id_rs2_used && sb_match(sb_ex_v_q, sb_ex_rd_q, sb_mem_v_q, sb_mem_rd_q, id_rs2)));
    mem_timeout_s = (state_q == ST_MEM_WAIT) && (mem_cnt_q == MEM_LIMIT);
    // Once the timeout hits, the access counts as complete and the pipe moves on.
    mem_block_s   = mem_req && !mem_ready && !mem_timeout_s;
    br_active_s   = ex_brx_taken || (state_q == ST_BR_FLUSH);
    mem_err_s     = mem_timeout_s && mem_req && !mem_ready;
  end

  // Output decode: reset > memory freeze > branch flush > hazard stall > run.
  always_comb begin
    pc_en_s      = 1'b1;
    ifid_en_s    = 1'b1;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    exmem_en_s   = 1'b1;
    run_decode_s = 1'b1;
    if (rst) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
      exmem_en_s   = 1'b0;
      run_decode_s = 1'b0;
    end else if (mem_block_s) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      exmem_en_s   = 1'b0;
      run_decode_s = 1'b0;
    end else if (br_active_s) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
      run_decode_s = 1'b0;
    end else if (hazard_s) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      idex_flush_s = 1'b1;
      run_decode_s = 1'b0;
    end else begin
      run_decode_s = 1'b1;
    end
  end

  // Next-state logic for the FSM and its branch/memory counters.
  always_comb begin
    state_d   = ST_RUN;
    br_cnt_d  = br_cnt_q;
    mem_cnt_d = 8'd0;
    if (mem_block_s) begin
      state_d   = ST_MEM_WAIT;
      mem_cnt_d = (state_q == ST_MEM_WAIT) ? (mem_cnt_q + 8'd1) : 8'd1;
    end else if (ex_brx_taken) begin
      // The detection cycle is the first flush cycle; BR_FLUSH covers the rest.
      br_cnt_d = BR_RELOAD;
      state_d  = (BR_RELOAD != 3'd0) ? ST_BR_FLUSH : ST_RUN;
    end else if (state_q == ST_BR_FLUSH) begin
      br_cnt_d = br_cnt_q - 3'd1;
      state_d  = (br_cnt_q > 3'd1) ? ST_BR_FLUSH : ST_RUN;
    end else if (hazard_s) begin
      state_d = ST_HAZ_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Scoreboard shift and stall counter next values.
  always_comb begin
    sb_ex_v_d   = sb_ex_v_q;
    sb_ex_rd_d  = sb_ex_rd_q;
    sb_mem_v_d  = sb_mem_v_q;
    sb_mem_rd_d = sb_mem_rd_q;
    stall_d     = stall_q;
    if (exmem_en_s) begin
      sb_mem_v_d  = sb_ex_v_q;
      sb_mem_rd_d = sb_ex_rd_q;
      // A bubbled ID instruction never reaches EX, so it must not be tracked.
      sb_ex_v_d   = id_valid && id_reg_en && !idex_flush_s;
      sb_ex_rd_d  = id_rd;
    end else begin
      sb_ex_v_d   = sb_ex_v_q;
      sb_mem_v_d  = sb_mem_v_q;
    end
    if (((state_q != ST_RUN) || !run_decode_s) && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State, counter and scoreboard registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      br_cnt_q    <= 3'd0;
      mem_cnt_q   <= 8'd0;
      stall_q     <= 8'd0;
      sb_ex_v_q   <= 1'b0;
      sb_ex_rd_q  <= '0;
      sb_mem_v_q  <= 1'b0;
      sb_mem_rd_q <= '0;
    end else begin
      state_q     <= state_d;
      br_cnt_q    <= br_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      stall_q     <= stall_d;
      sb_ex_v_q   <= sb_ex_v_d;
      sb_ex_rd_q  <= sb_ex_rd_d;
      sb_mem_v_q  <= sb_mem_v_d;
      sb_mem_rd_q <= sb_mem_rd_d;
    end
  end

  assign pc_en        = pc_en_s;
  assign ifid_en      = ifid_en_s;
  assign ifid_flush   = ifid_flush_s;
  assign idex_flush   = idex_flush_s;
  assign exmem_en     = exmem_en_s;
  assign mem_err      = mem_err_s && !rst;
  assign stall_cycles = rst ? 8'd0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed, self-checking bench for pipeline_hazard_ctrl with default
//   parameters (REG_AW=2, BR_FLUSH_CYCLES=2, MEM_TIMEOUT=15).
//   Inputs change 1 ns after the rising edge; outputs are checked 5 ns after.
//   Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [4:0] O_RUN    = 5'b11001;
  localparam logic [4:0] O_STALL  = 5'b00011;
  localparam logic [4:0] O_FLUSH  = 5'b11111;
  localparam logic [4:0] O_FREEZE = 5'b00000;
  localparam logic [4:0] O_RESET  = 5'b00110;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_en;
  logic       ex_brx_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, mem_err;
  logic [7:0] stall_cycles;
  logic [4:0] outs;

  int checks = 0;
  int errors = 0;

  assign outs = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en};

  pipeline_hazard_ctrl #(
    .REG_AW(2), .BR_FLUSH_CYCLES(2), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_en(id_reg_en),
    .ex_brx_taken(ex_brx_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 2'd0; id_rs2 = 2'd0; id_rd = 2'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_en = 1'b0;
    ex_brx_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle(); rst = 1'b1; idle();
    next_cycle(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (2) next_cycle();
    settle();
    checks++; if (outs !== O_RESET) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_RESET); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
    checks++; if (stall_cycles !== 8'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    next_cycle(); rst = 1'b0; settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL post_reset_run: got %b expected %b", outs, O_RUN); end
  endtask

  task automatic test_raw_hazard();
    do_reset();
    next_cycle(); id_valid = 1'b1; id_rd = 2'd1; id_reg_en = 1'b1; settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL raw_writer: got %b expected %b", outs, O_RUN); end
    next_cycle(); id_rd = 2'd2; id_reg_en = 1'b0; id_rs1 = 2'd1; id_rs1_used = 1'b1; settle();
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL raw_stall_ex: got %b expected %b", outs, O_STALL); end
    next_cycle(); settle();
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL raw_stall_mem: got %b expected %b", outs, O_STALL); end
    checks++; if (stall_cycles !== 8'd1) begin errors++; $display("FAIL raw_stall_cnt1: got %0d expected 1", stall_cycles); end
    next_cycle(); settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL raw_issue: got %b expected %b", outs, O_RUN); end
    next_cycle(); idle(); settle();
    checks++; if (stall_cycles !== 8'd3) begin errors++; $display("FAIL raw_stall_cnt3: got %0d expected 3", stall_cycles); end
  endtask

  task automatic test_rs_used();
    do_reset();
    next_cycle(); id_valid = 1'b1; id_rd = 2'd3; id_reg_en = 1'b1; settle();
    next_cycle(); id_reg_en = 1'b0; id_rd = 2'd0; id_rs1 = 2'd3; id_rs1_used = 1'b0;
    id_rs2 = 2'd0; id_rs2_used = 1'b1; settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL unused_src: got %b expected %b", outs, O_RUN); end
    next_cycle(); id_rs1 = 2'd0; id_rs2 = 2'd3; id_rs2_used = 1'b1; settle();
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL rs2_stall_mem: got %b expected %b", outs, O_STALL); end
    next_cycle(); settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL rs2_release: got %b expected %b", outs, O_RUN); end
  endtask

  task automatic test_branch();
    do_reset();
    next_cycle(); ex_brx_taken = 1'b1; settle();
    checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL br_cycle1: got %b expected %b", outs, O_FLUSH); end
    next_cycle(); ex_brx_taken = 1'b0; settle();
    checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL br_cycle2: got %b expected %b", outs, O_FLUSH); end
    next_cycle(); settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL br_done: got %b expected %b", outs, O_RUN); end
    checks++; if (stall_cycles !== 8'd2) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 2", stall_cycles); end
    // Back-to-back branch restarts the flush window.
    next_cycle(); ex_brx_taken = 1'b1; settle();
    next_cycle(); settle();
    next_cycle(); ex_brx_taken = 1'b0; settle();
    checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL br_restart_tail: got %b expected %b", outs, O_FLUSH); end
    next_cycle(); settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL br_restart_done: got %b expected %b", outs, O_RUN); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    next_cycle(); id_valid = 1'b1; id_rd = 2'd2; id_reg_en = 1'b1; settle();
    next_cycle(); idle(); mem_req = 1'b1; settle();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin next_cycle(); settle(); end
      checks++; if (outs !== O_FREEZE) begin errors++; $display("FAIL mem_freeze%0d: got %b expected %b", i, outs, O_FREEZE); end
    end
    // Scoreboard held: writer of r2 is still in sb_ex, so a reader stalls twice.
    next_cycle(); mem_ready = 1'b1; id_valid = 1'b1; id_rs1 = 2'd2; id_rs1_used = 1'b1; settle();
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL mem_sb_held_ex: got %b expected %b", outs, O_STALL); end
    next_cycle(); mem_req = 1'b0; mem_ready = 1'b0; settle();
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL mem_sb_held_mem: got %b expected %b", outs, O_STALL); end
    next_cycle(); settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL mem_after_run: got %b expected %b", outs, O_RUN); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mem_no_err: got %b expected 0", mem_err); end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    next_cycle(); mem_req = 1'b1; mem_ready = 1'b0; settle();
    for (int i = 1; i <= 15; i++) begin
      if (i > 1) begin next_cycle(); settle(); end
      checks++; if (outs !== O_FREEZE || mem_err !== 1'b0) begin errors++;
        $display("FAIL to_wait%0d: got outs=%b err=%b expected outs=%b err=0", i, outs, mem_err, O_FREEZE); end
    end
    next_cycle(); settle();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b expected 1", mem_err); end
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL to_release: got %b expected %b", outs, O_RUN); end
    next_cycle(); mem_req = 1'b0; settle();
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_err_once: got %b expected 0", mem_err); end
    checks++; if (stall_cycles !== 8'd16) begin errors++; $display("FAIL to_stall_cnt: got %0d expected 16", stall_cycles); end
    next_cycle(); settle();
    checks++; if (stall_cycles !== 8'd16) begin errors++; $display("FAIL to_state_run: got %0d expected 16", stall_cycles); end
  endtask

  task automatic test_haz_and_branch();
    do_reset();
    next_cycle(); id_valid = 1'b1; id_rd = 2'd1; id_reg_en = 1'b1; settle();
    next_cycle(); id_reg_en = 1'b0; id_rs1 = 2'd1; id_rs1_used = 1'b1; ex_brx_taken = 1'b1; settle();
    checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL hb_branch_wins: got %b expected %b", outs, O_FLUSH); end
    next_cycle(); idle(); settle();
    checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL hb_flush2: got %b expected %b", outs, O_FLUSH); end
    next_cycle(); settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL hb_run: got %b expected %b", outs, O_RUN); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    next_cycle(); mem_req = 1'b1; settle();
    next_cycle(); settle();
    checks++; if (outs !== O_FREEZE) begin errors++; $display("FAIL rm_frozen: got %b expected %b", outs, O_FREEZE); end
    next_cycle(); rst = 1'b1; settle();
    checks++; if (outs !== O_RESET || stall_cycles !== 8'd0) begin errors++;
      $display("FAIL rm_reset_outs: got outs=%b cnt=%0d expected outs=%b cnt=0", outs, stall_cycles, O_RESET); end
    next_cycle(); rst = 1'b0; mem_ready = 1'b1; settle();
    checks++; if (outs !== O_RUN || stall_cycles !== 8'd0) begin errors++;
      $display("FAIL rm_after: got outs=%b cnt=%0d expected outs=%b cnt=0", outs, stall_cycles, O_RUN); end
    // A pending branch flush must not survive reset.
    next_cycle(); idle(); ex_brx_taken = 1'b1; settle();
    next_cycle(); rst = 1'b1; ex_brx_taken = 1'b0; settle();
    next_cycle(); rst = 1'b0; settle();
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL rm_no_flush: got %b expected %b", outs, O_RUN); end
  endtask

  task automatic test_saturate();
    do_reset();
    next_cycle(); ex_brx_taken = 1'b1;
    repeat (300) next_cycle();
    settle();
    checks++; if (stall_cycles !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", stall_cycles); end
    next_cycle(); ex_brx_taken = 1'b0;
    next_cycle(); next_cycle(); settle();
    checks++; if (stall_cycles !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_rs_used();
    test_branch();
    test_mem_wait();
    test_mem_timeout();
    test_haz_and_branch();
    test_reset_midop();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
